// File: rtl/csr_controller.sv
// csr_controller: machine-mode CSR file (mie, mtvec, mscratch, mepc, mcause) with CSR ops and trap capture
// Ports: clk_i/rst_i (async active-low) clock and reset; opcode_i/addr_i/rs1_data_i/imm_data_i/write_enable_i CSR access;
//        trap_i/pc_i/mcause_i trap capture; read_data_o combinational read of addr_i; mie_o/mepc_o/mtvec_o register copies.
module csr_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  opcode_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] imm_data_i,
  input  logic        write_enable_i,
  input  logic        trap_i,
  output logic [31:0] read_data_o,
  output logic [31:0] mie_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtvec_o
);
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  logic [31:0] mie, mtvec, mscratch, mepc, mcause, src, wd;
  logic        op_ok, wr;
  // opcode[2] picks the immediate, opcode[1:0] picks write/set/clear; 000 and 100 are no-ops
  assign src   = opcode_i[2] ? imm_data_i : rs1_data_i;
  assign op_ok = opcode_i[1:0] != 2'b00;
  assign wr    = write_enable_i && op_ok;
  always_comb begin
    read_data_o = addr_i == A_MIE      ? mie      :
                  addr_i == A_MTVEC    ? mtvec    :
                  addr_i == A_MSCRATCH ? mscratch :
                  addr_i == A_MEPC     ? mepc     :
                  addr_i == A_MCAUSE   ? mcause   : 32'h0;
    wd          = !op_ok                  ? read_data_o        :
                  opcode_i[1:0] == 2'b01 ? src                :
                  opcode_i[1:0] == 2'b10 ? src | read_data_o  : ~src & read_data_o;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mie      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (wr && addr_i == A_MIE)      mie      <= wd;
      if (wr && addr_i == A_MTVEC)    mtvec    <= wd;
      if (wr && addr_i == A_MSCRATCH) mscratch <= wd;
      // a trap overrides any simultaneous CSR write to mepc/mcause
      if (trap_i) begin
        mepc   <= pc_i;
        mcause <= mcause_i;
      end else begin
        if (wr && addr_i == A_MEPC)   mepc     <= wd;
        if (wr && addr_i == A_MCAUSE) mcause   <= wd;
      end
    end
  end
  assign mie_o   = mie;
  assign mepc_o  = mepc;
  assign mtvec_o = mtvec;
endmodule

// File: tb/tb_csr_controller.sv
// tb_csr_controller: scoreboard bench for csr_controller with directed vectors
module tb_csr_controller;
  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;
  logic        clk_i = 0, rst_i = 0, write_enable_i = 0, trap_i = 0;
  logic [2:0]  opcode_i = 0;
  logic [11:0] addr_i = 0;
  logic [31:0] pc_i = 0, mcause_i = 0, rs1_data_i = 0, imm_data_i = 0;
  logic [31:0] read_data_o, mie_o, mepc_o, mtvec_o;
  typedef struct {
    string       nm;
    logic [31:0] mie, mepc, mtvec, rd;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] e_mie = 0, e_mepc = 0, e_mtvec = 0, d;

  csr_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .addr_i(addr_i), .pc_i(pc_i),
    .mcause_i(mcause_i), .rs1_data_i(rs1_data_i), .imm_data_i(imm_data_i),
    .write_enable_i(write_enable_i), .trap_i(trap_i), .read_data_o(read_data_o),
    .mie_o(mie_o), .mepc_o(mepc_o), .mtvec_o(mtvec_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void cmp(string nm, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, f, act, exp);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      wait (q.size() != 0);
      e = q.pop_front();
      cmp(e.nm, "mie", mie_o, e.mie);
      cmp(e.nm, "mepc", mepc_o, e.mepc);
      cmp(e.nm, "mtvec", mtvec_o, e.mtvec);
      cmp(e.nm, "rd", read_data_o, e.rd);
    end
  end

  task automatic push(string nm, logic [31:0] rd);
    q.push_back('{nm, e_mie, e_mepc, e_mtvec, rd});
  endtask

  // drives one cycle of stimulus, then queues the expected post-edge state
  task automatic step(string nm, logic [2:0] op, logic [11:0] a, logic [31:0] rs1, logic [31:0] imm,
                      logic we, logic tr, logic [31:0] pc, logic [31:0] mc, logic [31:0] rd);
    opcode_i = op; addr_i = a; rs1_data_i = rs1; imm_data_i = imm;
    write_enable_i = we; trap_i = tr; pc_i = pc; mcause_i = mc;
    @(posedge clk_i);
    #1 push(nm, rd);
    @(negedge clk_i);
  endtask

  initial begin
    step("rst_hold", RW, 12'h304, 32'hFFFF_FFFF, 0, 1, 1, 32'h1111_1111, 32'h2222_2222, 32'h0);
    rst_i = 1;
    step("rd_mie0", 0, 12'h304, 0, 0, 0, 0, 0, 0, 32'h0);
    step("rd_mtvec0", 0, 12'h305, 0, 0, 0, 0, 0, 0, 32'h0);
    step("rd_mscr0", 0, 12'h340, 0, 0, 0, 0, 0, 0, 32'h0);
    step("rd_mepc0", 0, 12'h341, 0, 0, 0, 0, 0, 0, 32'h0);
    step("rd_mcause0", 0, 12'h342, 0, 0, 0, 0, 0, 0, 32'h0);
    e_mtvec = 32'h1234_5678;
    step("rw_mtvec", RW, 12'h305, 32'h1234_5678, 0, 1, 0, 0, 0, 32'h1234_5678);
    e_mie = 32'h0000_00F0;
    step("rw_mie", RW, 12'h304, 32'h0000_00F0, 0, 1, 0, 0, 0, 32'h0000_00F0);
    e_mie = 32'h0000_00FF;
    step("rs_mie", RS, 12'h304, 32'h0000_000F, 0, 1, 0, 0, 0, 32'h0000_00FF);
    e_mie = 32'h0000_007E;
    step("rc_mie", RC, 12'h304, 32'h0000_0081, 0, 1, 0, 0, 0, 32'h0000_007E);
    step("rwi_mscr", RWI, 12'h340, $urandom, 5, 1, 0, 0, 0, 32'd5);
    step("rsi_mscr", RSI, 12'h340, $urandom, 2, 1, 0, 0, 0, 32'd7);
    step("rci_mscr", RCI, 12'h340, $urandom, 4, 1, 0, 0, 0, 32'd3);
    e_mepc = 32'h8000_0010;
    step("trap", 0, 12'h342, 0, 0, 0, 1, 32'h8000_0010, 32'h8000_000B, 32'h8000_000B);
    e_mepc = 32'h0000_00A0;
    step("trap_vs_mepc_wr", RW, 12'h341, 32'h0000_DEAD, 0, 1, 1, 32'h0000_00A0, 32'h2, 32'h0000_00A0);
    e_mepc = 32'h0000_00B0; e_mtvec = 32'h55;
    step("trap_and_mtvec_wr", RW, 12'h305, 32'h55, 0, 1, 1, 32'h0000_00B0, 32'h3, 32'h55);
    step("rd_mcause_trap", 0, 12'h342, 0, 0, 0, 0, 0, 0, 32'h3);
    step("bad_op100", 3'b100, 12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h7E);
    step("bad_op000", 3'b000, 12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h7E);
    step("wr_unmapped", RW, 12'h300, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 32'h0);
    step("csrr_mie", RS, 12'h304, 0, 0, 1, 0, 0, 0, 32'h7E);
    step("csrr_mtvec", RS, 12'h305, 0, 0, 1, 0, 0, 0, 32'h55);
    step("csrr_mscr", RS, 12'h340, 0, 0, 1, 0, 0, 0, 32'h3);
    step("csrr_mepc", RS, 12'h341, 0, 0, 1, 0, 0, 0, 32'hB0);
    step("csrr_mcause", RS, 12'h342, 0, 0, 1, 0, 0, 0, 32'h3);
    step("csrr_unmapped", RS, 12'h300, 0, 0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      e_mepc = d;
      step($sformatf("b2b_mepc%0d", i), RW, 12'h341, d, 0, 1, 0, 0, 0, d);
    end
    opcode_i = RW; addr_i = 12'h305; rs1_data_i = 32'hCAFE_F00D; write_enable_i = 1;
    #2 rst_i = 0;
    e_mie = 0; e_mepc = 0; e_mtvec = 0;
    #1 push("async_rst", 32'h0);
    #1 addr_i = 12'h340;
    #1 push("async_rst_mscr", 32'h0);
    @(posedge clk_i);
    #1 push("rst_no_write", 32'h0);
    for (int i = 0; i < 100 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL monitor_drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
